// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - machine-timer interrupt pending/request/handler controller
//
// Turns the one-cycle timer overflow pulse into an MTIP pending bit and a
// held interrupt request to the trap logic. Requests are gated by mie.MTIE and
// mstatus.MIE. Handler entry is irq_ack, handler exit is mret. Ticks that
// arrive while MTIP is already pending are counted in a saturating counter.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   tick_i        timer overflow pulse
//   mtie_i        mie.MTIE
//   gie_i         mstatus.MIE
//   irq_ack_i     pipeline took the timer trap this cycle
//   mret_i        mret committed this cycle
//   pend_clr_i    CSR write clearing MTIP (also zeroes the miss counter)
//   irq_req_o     timer interrupt request (state REQ)
//   mtip_o        MTIP pending bit
//   in_handler_o  timer handler active (state HANDLER)
//   miss_cnt_o    saturating count of ticks lost while MTIP was set

module timer_irq_ctrl #(
   parameter int MISS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_i,
   input  logic              mtie_i,
   input  logic              gie_i,
   input  logic              irq_ack_i,
   input  logic              mret_i,
   input  logic              pend_clr_i,
   output logic              irq_req_o,
   output logic              mtip_o,
   output logic              in_handler_o,
   output logic [MISS_W-1:0] miss_cnt_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      REQ     = 2'd2,
      HANDLER = 2'd3
   } state_t;

   localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

   state_t            state;
   logic              mtip;
   logic [MISS_W-1:0] miss_cnt;

   logic enabled;
   assign enabled = mtie_i && gie_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mtip     <= 1'b0;
         miss_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A tick that coincided with a clear leaves mtip set while the
               // state took the clear path; re-enter through PEND from here.
               if (tick_i || mtip) begin
                  state <= PEND;
               end
               if (tick_i) begin
                  mtip <= 1'b1;
               end
            end
            PEND: begin
               if (pend_clr_i && !tick_i) begin
                  mtip  <= 1'b0;
                  state <= IDLE;
               end else begin
                  if (tick_i) begin
                     mtip <= 1'b1;
                  end
                  if (enabled) begin
                     state <= REQ;
                  end
               end
            end
            REQ: begin
               if (irq_ack_i) begin
                  mtip  <= tick_i;
                  state <= HANDLER;
               end else if (pend_clr_i) begin
                  mtip  <= tick_i;
                  state <= IDLE;
               end else begin
                  if (tick_i) begin
                     mtip <= 1'b1;
                  end
                  if (!enabled) begin
                     state <= PEND;
                  end
               end
            end
            HANDLER: begin
               if (tick_i) begin
                  mtip <= 1'b1;
               end else if (pend_clr_i) begin
                  mtip <= 1'b0;
               end
               // Exit decision uses the post-update pending value so a tick in
               // the mret cycle is not lost.
               if (mret_i) begin
                  state <= (tick_i || (mtip && !pend_clr_i)) ? PEND : IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (pend_clr_i) begin
            miss_cnt <= '0;
         end else if (tick_i && mtip && !irq_ack_i && miss_cnt != MISS_MAX) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end

   assign irq_req_o    = (state == REQ);
   assign in_handler_o = (state == HANDLER);
   assign mtip_o       = mtip;
   assign miss_cnt_o   = miss_cnt;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - self-checking bench for timer_irq_ctrl

module tb_timer_irq_ctrl;

   localparam int MISS_W   = 4;
   localparam int MISS_MAX = (1 << MISS_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              tick_i = 1'b0;
   logic              mtie_i = 1'b0;
   logic              gie_i = 1'b0;
   logic              irq_ack_i = 1'b0;
   logic              mret_i = 1'b0;
   logic              pend_clr_i = 1'b0;
   logic              irq_req_o;
   logic              mtip_o;
   logic              in_handler_o;
   logic [MISS_W-1:0] miss_cnt_o;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 1'b0;

   timer_irq_ctrl #(.MISS_W(MISS_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (tick_i),
      .mtie_i       (mtie_i),
      .gie_i        (gie_i),
      .irq_ack_i    (irq_ack_i),
      .mret_i       (mret_i),
      .pend_clr_i   (pend_clr_i),
      .irq_req_o    (irq_req_o),
      .mtip_o       (mtip_o),
      .in_handler_o (in_handler_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk = ~clk;

   // Model: the controller is in one of four phases -- quiet, pending but not
   // requesting, requesting, or servicing. Pending bit and lost-tick count are
   // tracked as a bit and an integer.
   localparam int PH_QUIET = 0, PH_WAIT = 1, PH_ASK = 2, PH_SERVE = 3;

   int m_ph = PH_QUIET;
   bit m_mtip = 1'b0;
   int m_miss = 0;

   int ph_n;
   bit mtip_n;
   int miss_n;

   always_comb begin
      bit clear;
      ph_n   = m_ph;
      clear  = 1'b0;
      if (m_ph == PH_ASK && irq_ack_i) clear = 1'b1;
      if (m_ph != PH_QUIET && pend_clr_i) clear = 1'b1;
      // a tick always wins over any clear
      mtip_n = tick_i ? 1'b1 : (clear ? 1'b0 : m_mtip);

      if (m_ph == PH_QUIET) begin
         if (tick_i || m_mtip) ph_n = PH_WAIT;
      end else if (m_ph == PH_WAIT) begin
         if (pend_clr_i && !tick_i) ph_n = PH_QUIET;
         else if (mtie_i && gie_i)  ph_n = PH_ASK;
      end else if (m_ph == PH_ASK) begin
         if (irq_ack_i)             ph_n = PH_SERVE;
         else if (pend_clr_i)       ph_n = PH_QUIET;
         else if (!(mtie_i && gie_i)) ph_n = PH_WAIT;
      end else begin
         if (mret_i) ph_n = mtip_n ? PH_WAIT : PH_QUIET;
      end

      if (pend_clr_i) miss_n = 0;
      else if (tick_i && m_mtip && !irq_ack_i) miss_n = (m_miss + 1 > MISS_MAX) ? MISS_MAX : m_miss + 1;
      else miss_n = m_miss;
   end

   always @(posedge clk) begin
      if (reset) begin
         m_ph   <= PH_QUIET;
         m_mtip <= 1'b0;
         m_miss <= 0;
      end else begin
         m_ph   <= ph_n;
         m_mtip <= mtip_n;
         m_miss <= miss_n;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_req",  int'(irq_req_o),    int'(m_ph == PH_ASK));
         chk("model_hdl",  int'(in_handler_o), int'(m_ph == PH_SERVE));
         chk("model_mtip", int'(mtip_o),       int'(m_mtip));
         chk("model_miss", int'(miss_cnt_o),   m_miss);
      end
   end

   task automatic step(input bit t, input bit a, input bit m, input bit c);
      tick_i     = t;
      irq_ack_i  = a;
      mret_i     = m;
      pend_clr_i = c;
      @(posedge clk);
      #1;
      tick_i     = 1'b0;
      irq_ack_i  = 1'b0;
      mret_i     = 1'b0;
      pend_clr_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic outs(input string name, input int req, input int mtip, input int hdl, input int miss);
      chk({name, "_req"},  int'(irq_req_o),    req);
      chk({name, "_mtip"}, int'(mtip_o),       mtip);
      chk({name, "_hdl"},  int'(in_handler_o), hdl);
      chk({name, "_miss"}, int'(miss_cnt_o),   miss);
   endtask

   initial begin
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      chk_en = 1'b1;
      outs("reset", 0, 0, 0, 0);

      // Basic flow: tick -> mtip, then request, ack, mret.
      mtie_i = 1'b1; gie_i = 1'b1;
      idle(3);
      step(1, 0, 0, 0);  outs("basic_tick", 0, 1, 0, 0);
      idle(1);           outs("basic_req",  1, 1, 0, 0);
      idle(1);           outs("basic_hold", 1, 1, 0, 0);
      step(0, 1, 0, 0);  outs("basic_ack",  0, 0, 1, 0);
      idle(4);           outs("basic_hdl",  0, 0, 1, 0);
      step(0, 0, 1, 0);  outs("basic_mret", 0, 0, 0, 0);
      idle(2);

      // Gating by the global enable, then withdrawal on MTIE drop.
      gie_i = 1'b0;
      step(1, 0, 0, 0);  outs("gate_tick", 0, 1, 0, 0);
      idle(20);          outs("gate_wait", 0, 1, 0, 0);
      gie_i = 1'b1;
      idle(1);           outs("gate_on",   1, 1, 0, 0);
      mtie_i = 1'b0;
      idle(1);           outs("gate_drop", 0, 1, 0, 0);
      step(0, 0, 0, 1);  outs("gate_clr",  0, 0, 0, 0);
      mtie_i = 1'b1;
      idle(2);

      // Tick during handler, then mret; then tick and mret together.
      step(1, 0, 0, 0);
      idle(1);
      step(0, 1, 0, 0);  outs("hdl_enter", 0, 0, 1, 0);
      step(1, 0, 0, 0);  outs("hdl_tick",  0, 1, 1, 0);
      step(0, 0, 1, 0);  outs("hdl_mret",  0, 1, 0, 0);
      idle(1);           outs("hdl_rereq", 1, 1, 0, 0);
      step(0, 1, 0, 0);  outs("hdl_ack2",  0, 0, 1, 0);
      step(1, 0, 1, 0);  outs("hdl_tkmret", 0, 1, 0, 0);
      idle(1);           outs("hdl_rereq2", 1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);  outs("hdl_exit",  0, 0, 0, 0);

      // Missed ticks saturate; pend_clr wipes mtip and count.
      gie_i = 1'b0;
      step(1, 0, 0, 0);  outs("miss_first", 0, 1, 0, 0);
      for (int i = 0; i < 14; i++) step(1, 0, 0, 0);
      outs("miss_14", 0, 1, 0, 14);
      step(1, 0, 0, 0);  outs("miss_15", 0, 1, 0, 15);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      outs("miss_sat", 0, 1, 0, 15);
      step(0, 0, 0, 1);  outs("miss_clr", 0, 0, 0, 0);
      idle(2);           outs("miss_idle", 0, 0, 0, 0);

      // Simultaneous tick + ack, and tick + pend_clr in PEND.
      gie_i = 1'b1;
      step(1, 0, 0, 0);
      idle(1);
      step(1, 1, 0, 0);  outs("sim_tkack", 0, 1, 1, 0);
      step(0, 0, 1, 0);  outs("sim_mret",  0, 1, 0, 0);
      idle(1);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      gie_i = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);  outs("sim_miss1", 0, 1, 0, 1);
      step(1, 0, 0, 1);  outs("sim_tkclr", 0, 1, 0, 0);
      step(0, 0, 0, 1);  outs("sim_clr",   0, 0, 0, 0);

      // Tick + pend_clr while requesting (model-checked path).
      gie_i = 1'b1;
      step(1, 0, 0, 0);
      idle(1);
      step(1, 0, 0, 1);
      idle(3);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      idle(1);

      // Reset while requesting; stray ack/mret afterwards do nothing.
      gie_i = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      gie_i = 1'b1;
      idle(1);           outs("rst_pre", 1, 1, 0, 1);
      reset = 1'b1;
      idle(1);           outs("rst_hit", 0, 0, 0, 0);
      reset = 1'b0;
      step(0, 1, 0, 0);  outs("rst_ack", 0, 0, 0, 0);
      step(0, 0, 1, 0);  outs("rst_mret", 0, 0, 0, 0);
      idle(2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Receives the 1-cycle timer overflow pulse produced by the free-running timer counter and turns it into a machine-timer interrupt request for the pipeline's trap logic. It maintains the MTIP pending bit, gates requests with the CSR enables (mie.MTIE, mstatus.MIE), and holds a request/acknowledge handshake with the pipeline. It tracks handler entry and exit through mret and counts ticks lost while an interrupt was already pending. It sits between the timer counter and the CSR/trap unit.

## Interface
- MISS_W, 4, width of the saturating missed-tick counter
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- tick_i  input  1  timer overflow pulse, one cycle wide
- mtie_i  input  1  mie.MTIE from CSR file
- gie_i  input  1  mstatus.MIE from CSR file
- irq_ack_i  input  1  pipeline has taken the timer trap this cycle
- mret_i  input  1  mret committed this cycle
- pend_clr_i  input  1  CSR write clearing MTIP
- irq_req_o  output  1  timer interrupt request to trap logic
- mtip_o  output  1  MTIP pending bit, for mip read-back
- in_handler_o  output  1  timer handler active
- miss_cnt_o  output  MISS_W  ticks lost while MTIP already set, saturating

## Operation
- Moore FSM with states IDLE, PEND, REQ, HANDLER. All outputs are decoded from registered state or registers, with no combinational path from inputs.
- mtip is a separate register. irq_req_o = (state==REQ). in_handler_o = (state==HANDLER).
- IDLE: tick_i -> mtip<=1, next PEND. All other inputs are ignored.
- PEND: pend_clr_i without tick_i -> mtip<=0, next IDLE. Otherwise, if mtie_i && gie_i -> next REQ. Otherwise stay.
- REQ: irq_req_o held high until irq_ack_i.
  - irq_ack_i -> mtip<=0, next HANDLER.
  - Without ack: pend_clr_i -> mtip<=0, next IDLE (request withdrawn).
  - Without ack: mtie_i or gie_i low -> next PEND (request withdrawn, mtip kept).
  - Priority: ack > pend_clr > enable drop.
- HANDLER: no nesting and no request. A tick_i sets mtip<=1 but the state remains HANDLER. mret_i -> next PEND if mtip (including a tick in the same cycle), else IDLE.
- irq_ack_i outside REQ and mret_i outside HANDLER are ignored.
- pend_clr_i in HANDLER clears mtip, unless tick_i is also asserted that cycle.
- Same-cycle tick_i with a clear (ack or pend_clr): the set wins. mtip ends at 1, and the state follows the clear path, then re-enters via PEND.
- Missed tick: tick_i while mtip==1 and neither irq_ack_i nor pend_clr_i is asserted that cycle -> miss_cnt += 1, saturating at 2^MISS_W-1 (never wraps).
- pend_clr_i zeroes miss_cnt. Clear has priority over increment.

## Timing
- Reset: state IDLE, mtip_o=0, irq_req_o=0, in_handler_o=0, miss_cnt_o=0. Reset asserted mid-operation (any state) forces this on the next edge and drops irq_req_o immediately after that edge.
- Latency with enables high: tick_i sampled at edge N gives mtip_o=1 after N, and irq_req_o=1 after edge N+1 (2 cycles tick-to-request).
- Ack handshake: irq_ack_i sampled at edge M gives irq_req_o=0 and in_handler_o=1 after M. The pipeline must not assert ack without req.
- mret_i at edge K gives in_handler_o=0 after K. If pending, irq_req_o returns after K+1.
- Enables rising while in PEND: request appears one cycle after they are sampled high.

## Test plan
- Basic: reset, mtie=gie=1, tick at cycle 5 -> mtip=1 at 6, req=1 at 7; ack at 9 -> req=0, mtip=0, in_handler=1 at 10; mret at 14 -> IDLE at 15, all outputs 0.
- Gating: gie=0, tick -> mtip=1, req stays 0 for 20 cycles; set gie=1 at cycle 30 -> req=1 at 31; drop mtie while req high and no ack -> req=0 next cycle, mtip still 1.
- Tick during handler: tick while HANDLER -> mtip=1, no req; mret -> PEND, then req rises one cycle later. Tick and mret in the same cycle gives the same result.
- Missed ticks: gie=0, 20 ticks -> miss_cnt saturates at 15 (MISS_W=4); pend_clr -> mtip=0, miss_cnt=0, state IDLE.
- Simultaneous events: tick and ack in the same cycle -> HANDLER with mtip=1, miss_cnt unchanged; tick and pend_clr in PEND -> mtip=1, miss_cnt=0.
- Reset mid-request: assert reset while req=1 -> next cycle req=0, mtip=0, miss_cnt=0; a stray ack or mret afterwards has no effect.
